// File: rtl/hack_memory_ctrl_pkg.sv
// Shared defaults and scanner state encoding for the Hack data-memory controller.
package hack_mem_pkg;

   localparam int DEF_DATA_W       = 16;
   localparam int DEF_ADDR_W       = 15;
   localparam int DEF_RAM_DEPTH    = 16384;
   localparam int DEF_SCREEN_BASE  = 16384;
   localparam int DEF_SCREEN_WORDS = 8192;
   localparam int DEF_KBD_ADDR     = 24576;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_e;

endpackage

// File: rtl/hack_memory_ctrl_if.sv
// CPU data bus, keyboard input and pixel-stream handshake bundled for the controller.
interface hack_memory_ctrl_if
   import hack_mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);

   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_in;
   logic              cpu_ld;
   logic [DATA_W-1:0] cpu_out;
   logic [DATA_W-1:0] kbd_code;
   logic              kbd_valid;
   logic              scan_start;
   logic [DATA_W-1:0] pix_word;
   logic              pix_valid;
   logic              pix_ready;
   logic              frame_done;

   modport master (
      output cpu_addr, cpu_in, cpu_ld, kbd_code, kbd_valid, scan_start, pix_ready,
      input  cpu_out, pix_word, pix_valid, frame_done
   );

   modport slave (
      input  cpu_addr, cpu_in, cpu_ld, kbd_code, kbd_valid, scan_start, pix_ready,
      output cpu_out, pix_word, pix_valid, frame_done
   );

endinterface

// File: rtl/hack_memory_ctrl_scanner.sv
// Screen scan-out FSM: walks the frame buffer and offers one word per valid/ready handshake.
module hack_screen_scanner
   import hack_mem_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int SCREEN_WORDS = DEF_SCREEN_WORDS,
   parameter int CONTINUOUS   = 0,
   parameter int PTR_W        = (SCREEN_WORDS > 1) ? $clog2(SCREEN_WORDS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scan_start_i,
   input  logic              pix_ready_i,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic [PTR_W-1:0]  rd_addr_o,
   output logic [DATA_W-1:0] pix_word_o,
   output logic              pix_valid_o,
   output logic              frame_done_o
);

   localparam logic [0:0] S_IDLE = IDLE;
   localparam logic [0:0] S_SCAN = SCAN;

   logic [0:0]        state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic              vld_q, vld_d;
   logic              done_q, done_d;
   logic              hs;
   logic              last;

   assign hs   = vld_q && pix_ready_i;
   assign last = (ptr_q == PTR_W'(SCREEN_WORDS - 1));

   // The fetch address is always the word that would be loaded next: 0 on start or wrap, else ptr+1.
   assign rd_addr_o = ((state_q == S_SCAN) && !last) ? ptr_q + PTR_W'(1) : '0;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      word_d  = word_q;
      vld_d   = vld_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (scan_start_i) begin
               ptr_d   = '0;
               word_d  = rd_data_i;
               vld_d   = 1'b1;
               state_d = S_SCAN;
            end
         end
         default: begin
            if (hs) begin
               if (!last) begin
                  ptr_d  = ptr_q + PTR_W'(1);
                  word_d = rd_data_i;
               end else begin
                  done_d = 1'b1;
                  if (CONTINUOUS != 0) begin
                     ptr_d  = '0;
                     word_d = rd_data_i;
                  end else begin
                     vld_d   = 1'b0;
                     state_d = S_IDLE;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         word_q  <= '0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         word_q  <= word_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
      end
   end

   assign pix_word_o   = word_q;
   assign pix_valid_o  = vld_q;
   assign frame_done_o = done_q;

endmodule

// File: rtl/hack_memory_ctrl.sv
// Hack data memory: RAM / screen / keyboard decode for the CPU plus a read-only scan-out port.
module hack_memory_ctrl
   import hack_mem_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int RAM_DEPTH    = DEF_RAM_DEPTH,
   parameter int SCREEN_BASE  = DEF_SCREEN_BASE,
   parameter int SCREEN_WORDS = DEF_SCREEN_WORDS,
   parameter int KBD_ADDR     = DEF_KBD_ADDR,
   parameter int CONTINUOUS   = 0
) (
   input logic               clk,
   input logic               rst,
   hack_memory_ctrl_if.slave bus
);

   localparam int PTR_W  = (SCREEN_WORDS > 1) ? $clog2(SCREEN_WORDS) : 1;
   localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

   logic [DATA_W-1:0] ram_q [RAM_DEPTH];
   logic [DATA_W-1:0] scr_q [SCREEN_WORDS];
   logic [DATA_W-1:0] kbd_q;

   logic [31:0]       addr_w;
   logic              is_ram, is_scr, is_kbd;
   logic [RAM_AW-1:0] ram_idx;
   logic [PTR_W-1:0]  scr_idx;
   logic [PTR_W-1:0]  scan_rd_addr;
   logic [DATA_W-1:0] scan_rd_data;

   assign addr_w  = 32'(bus.cpu_addr);
   assign is_ram  = addr_w < 32'(RAM_DEPTH);
   assign is_scr  = !is_ram && (addr_w >= 32'(SCREEN_BASE))
                    && (addr_w < 32'(SCREEN_BASE + SCREEN_WORDS));
   assign is_kbd  = !is_ram && !is_scr && (addr_w == 32'(KBD_ADDR));
   assign ram_idx = RAM_AW'(addr_w);
   assign scr_idx = PTR_W'(addr_w - 32'(SCREEN_BASE));

   always_ff @(posedge clk) begin
      if (bus.cpu_ld && is_ram) begin
         ram_q[ram_idx] <= bus.cpu_in;
      end
   end

   // Scanner reads sample the array before this write lands, so a same-edge collision yields old data.
   always_ff @(posedge clk) begin
      if (bus.cpu_ld && is_scr) begin
         scr_q[scr_idx] <= bus.cpu_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kbd_q <= '0;
      end else if (bus.kbd_valid) begin
         kbd_q <= bus.kbd_code;
      end
   end

   always_comb begin
      bus.cpu_out = '0;
      if (is_ram) begin
         bus.cpu_out = ram_q[ram_idx];
      end else if (is_scr) begin
         bus.cpu_out = scr_q[scr_idx];
      end else if (is_kbd) begin
         bus.cpu_out = kbd_q;
      end
   end

   assign scan_rd_data = scr_q[scan_rd_addr];

   hack_screen_scanner #(
      .DATA_W      (DATA_W),
      .SCREEN_WORDS(SCREEN_WORDS),
      .CONTINUOUS  (CONTINUOUS),
      .PTR_W       (PTR_W)
   ) u_scanner (
      .clk         (clk),
      .rst         (rst),
      .scan_start_i(bus.scan_start),
      .pix_ready_i (bus.pix_ready),
      .rd_data_i   (scan_rd_data),
      .rd_addr_o   (scan_rd_addr),
      .pix_word_o  (bus.pix_word),
      .pix_valid_o (bus.pix_valid),
      .frame_done_o(bus.frame_done)
   );

endmodule

// File: tb/tb_hack_memory_ctrl.sv
// Bench for hack_memory_ctrl: vector table, full-frame scan, backpressure, reset abort,
// randomized CPU traffic against a flat memory model, and a continuous-mode instance.
module tb_hack_memory_ctrl;

   localparam int SW  = 8192;
   localparam int SW2 = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hack_memory_ctrl_if #(.DATA_W(16), .ADDR_W(15)) bus1 ();
   hack_memory_ctrl_if #(.DATA_W(16), .ADDR_W(15)) bus2 ();

   hack_memory_ctrl u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus1)
   );

   hack_memory_ctrl #(.SCREEN_WORDS(SW2), .CONTINUOUS(1)) u_cont (
      .clk(clk),
      .rst(rst),
      .bus(bus2)
   );

   int total = 0;
   int bad   = 0;

   logic [15:0] ram_m [16384];
   logic [15:0] scr_m [SW];
   logic [15:0] kbd_m;
   logic [15:0] c_scr [SW2];

   typedef struct {
      logic        wr;
      int          waddr;
      logic [15:0] wdata;
      logic        kv;
      logic [15:0] kcode;
      int          raddr;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] m_read(input int a);
      if (a < 16384) return ram_m[a];
      if (a >= 16384 && a < 16384 + SW) return scr_m[a - 16384];
      if (a == 24576) return kbd_m;
      return 16'h0000;
   endfunction

   function automatic void m_write(input int a, input logic [15:0] d);
      if (a < 16384) ram_m[a] = d;
      else if (a < 16384 + SW) scr_m[a - 16384] = d;
   endfunction

   // Apply the model for the current inputs, then advance one clock and settle.
   task automatic cyc();
      if (!rst && bus1.cpu_ld) m_write(int'(bus1.cpu_addr), bus1.cpu_in);
      if (rst) kbd_m = 16'h0000;
      else if (bus1.kbd_valid) kbd_m = bus1.kbd_code;
      if (!rst && bus2.cpu_ld && int'(bus2.cpu_addr) >= 16384 && int'(bus2.cpu_addr) < 16384 + SW2)
         c_scr[int'(bus2.cpu_addr) - 16384] = bus2.cpu_in;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k, dones, done_at, gaps, n;
      logic exp_done;
      int ram_pool [8];
      int a;

      bus1.cpu_addr = '0; bus1.cpu_in = '0; bus1.cpu_ld = 0; bus1.kbd_code = '0;
      bus1.kbd_valid = 0; bus1.scan_start = 0; bus1.pix_ready = 0;
      bus2.cpu_addr = '0; bus2.cpu_in = '0; bus2.cpu_ld = 0; bus2.kbd_code = '0;
      bus2.kbd_valid = 0; bus2.scan_start = 0; bus2.pix_ready = 0;
      kbd_m = 16'h0000;

      vecs[0] = '{1'b1, 5,      16'h1234, 1'b0, 16'h0000, 5,      16'h1234};
      vecs[1] = '{1'b0, 0,      16'h0000, 1'b0, 16'h0000, 'h7000, 16'h0000};
      vecs[2] = '{1'b0, 0,      16'h0000, 1'b1, 16'h0041, 'h6000, 16'h0041};
      vecs[3] = '{1'b1, 'h6000, 16'hFFFF, 1'b0, 16'h0000, 'h6000, 16'h0041};
      vecs[4] = '{1'b1, 'h4000, 16'hA5A5, 1'b0, 16'h0000, 'h4000, 16'hA5A5};
      vecs[5] = '{1'b1, 'h3FFF, 16'h0BAD, 1'b0, 16'h0000, 'h3FFF, 16'h0BAD};
      vecs[6] = '{1'b1, 'h5FFF, 16'hCAFE, 1'b0, 16'h0000, 'h5FFF, 16'hCAFE};
      vecs[7] = '{1'b1, 'h6001, 16'h1111, 1'b0, 16'h0000, 'h6001, 16'h0000};
      vecs[8] = '{1'b1, 'h7FFF, 16'h2222, 1'b0, 16'h0000, 'h7FFF, 16'h0000};
      vecs[9] = '{1'b0, 0,      16'h0000, 1'b0, 16'h0000, 5,      16'h1234};

      // Reset state
      cyc();
      cyc();
      rst = 1'b0;
      bus1.cpu_addr = 15'h6000;
      #1;
      chk("rst_pix_valid", bus1.pix_valid, 1'b0);
      chk("rst_frame_done", bus1.frame_done, 1'b0);
      chk("rst_pix_word", bus1.pix_word, 16'h0000);
      chk("rst_kbd", bus1.cpu_out, 16'h0000);
      chk("rst_cont_valid", bus2.pix_valid, 1'b0);

      // Decode / keyboard vectors
      for (int i = 0; i < 10; i++) begin
         bus1.cpu_ld = vecs[i].wr;
         bus1.cpu_addr = 15'(vecs[i].waddr);
         bus1.cpu_in = vecs[i].wdata;
         bus1.kbd_valid = vecs[i].kv;
         bus1.kbd_code = vecs[i].kcode;
         cyc();
         bus1.cpu_ld = 0;
         bus1.kbd_valid = 0;
         bus1.cpu_addr = 15'(vecs[i].raddr);
         #1;
         chk($sformatf("vec%0d", i), bus1.cpu_out, vecs[i].exp);
      end

      // Fill screen[i] = i
      for (int i = 0; i < SW; i++) begin
         bus1.cpu_ld = 1;
         bus1.cpu_addr = 15'(16384 + i);
         bus1.cpu_in = 16'(i);
         cyc();
      end
      bus1.cpu_ld = 0;

      // Full frame with pix_ready held high
      bus1.scan_start = 1;
      cyc();
      bus1.scan_start = 0;
      bus1.pix_ready = 1;
      k = 0; dones = 0; done_at = -1; gaps = 0;
      for (int c = 0; c < SW + 4; c++) begin
         if (bus1.frame_done) begin dones++; done_at = c; end
         if (c < SW && !bus1.pix_valid) gaps++;
         if (bus1.pix_valid) begin
            if (k < SW) chk("frame_word", bus1.pix_word, scr_m[k]);
            k++;
         end
         cyc();
      end
      chk("frame_count", k, SW);
      chk("frame_gaps", gaps, 0);
      chk("frame_done_cnt", dones, 1);
      chk("frame_done_at", done_at, SW);
      chk("frame_end_valid", bus1.pix_valid, 1'b0);

      // Backpressure at ptr=10 with a CPU write to the offered word
      bus1.scan_start = 1;
      cyc();
      bus1.scan_start = 0;
      bus1.pix_ready = 1;
      repeat (10) cyc();
      chk("bp_pre", bus1.pix_word, 16'd10);
      bus1.pix_ready = 0;
      for (int i = 0; i < 3; i++) begin
         bus1.cpu_ld = 1;
         bus1.cpu_addr = 15'h400A;
         bus1.cpu_in = 16'hBEEF;
         cyc();
         bus1.cpu_ld = 0;
         chk("bp_hold", bus1.pix_word, 16'd10);
         chk("bp_valid", bus1.pix_valid, 1'b1);
      end
      bus1.cpu_addr = 15'h400A;
      #1;
      chk("bp_cpu_sees_new", bus1.cpu_out, 16'hBEEF);
      bus1.pix_ready = 1;
      cyc();
      chk("bp_next", bus1.pix_word, 16'd11);
      repeat (89) cyc();
      chk("at_ptr100", bus1.pix_word, 16'd100);

      // Reset mid-scan aborts without frame_done
      rst = 1;
      cyc();
      chk("abort_valid", bus1.pix_valid, 1'b0);
      chk("abort_done", bus1.frame_done, 1'b0);
      rst = 0;
      cyc();
      chk("abort_done2", bus1.frame_done, 1'b0);
      chk("abort_valid2", bus1.pix_valid, 1'b0);
      bus1.scan_start = 1;
      cyc();
      bus1.scan_start = 0;
      chk("restart_valid", bus1.pix_valid, 1'b1);
      chk("restart_w0", bus1.pix_word, scr_m[0]);
      cyc();
      chk("restart_w1", bus1.pix_word, scr_m[1]);
      bus1.pix_ready = 0;

      // Randomized CPU / keyboard traffic against the flat model
      ram_pool = '{0, 1, 5, 100, 'h1000, 'h2ABC, 'h3FFE, 'h3FFF};
      for (int i = 0; i < 8; i++) begin
         bus1.cpu_ld = 1;
         bus1.cpu_addr = 15'(ram_pool[i]);
         bus1.cpu_in = 16'($urandom);
         cyc();
      end
      bus1.cpu_ld = 0;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 4))
            0, 1: a = ram_pool[$urandom_range(0, 7)];
            2: a = 16384 + int'($urandom_range(0, SW - 1));
            3: a = 24576;
            default: a = 24577 + int'($urandom_range(0, 32767 - 24577));
         endcase
         bus1.cpu_addr = 15'(a);
         bus1.cpu_ld = 1'($urandom_range(0, 1));
         bus1.cpu_in = 16'($urandom);
         bus1.kbd_valid = ($urandom_range(0, 3) == 0);
         bus1.kbd_code = 16'($urandom);
         #1;
         chk("rand_rd", bus1.cpu_out, m_read(a));
         cyc();
      end
      bus1.cpu_ld = 0;
      bus1.kbd_valid = 0;

      // Continuous mode, 8-word screen
      for (int i = 0; i < SW2; i++) begin
         bus2.cpu_ld = 1;
         bus2.cpu_addr = 15'(16384 + i);
         bus2.cpu_in = 16'(i * 16'h0111 + 3);
         cyc();
      end
      bus2.cpu_ld = 0;
      bus2.scan_start = 1;
      cyc();
      bus2.scan_start = 0;
      n = 0;
      exp_done = 1'b0;
      for (int c = 0; c < 80; c++) begin
         bus2.pix_ready = (c < 20) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
         chk("cont_valid", bus2.pix_valid, 1'b1);
         chk("cont_word", bus2.pix_word, c_scr[n % SW2]);
         chk("cont_done", bus2.frame_done, exp_done);
         exp_done = bus2.pix_ready && (n % SW2 == SW2 - 1);
         if (bus2.pix_ready) n++;
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
